// File: rtl/intensity_cell_ctrl.sv
// rtl/intensity_cell_ctrl.sv - cell sequencer around the LiDAR intensity accumulator
//
// Groups a stream of 8-bit point intensities into cells of POINTS_PER_CELL
// points, drives the external accumulator (enable, clear, operand), captures
// each finished cell sum, thresholds it and presents it downstream with its
// cell index over a valid/ready handshake.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - sample handshake; in_intensity, in_sof with it
//   acc_ce/acc_clr/acc_a- accumulator enable, clear, operand
//   acc_y               - accumulator registered sum
//   cell_valid/ready    - result handshake; cell_sum, cell_idx, cell_hit
//   frame_done          - pulse when the last cell of a frame is accepted
//   sof_err             - pulse when a misplaced start-of-frame forces resync
module intensity_cell_ctrl #(
    parameter int          POINTS_PER_CELL = 96,
    parameter int          CELLS_PER_ROW   = 30,
    parameter logic [19:0] THRESHOLD       = 20'd12000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_intensity,
    input  logic        in_sof,
    output logic        acc_ce,
    output logic        acc_clr,
    output logic [7:0]  acc_a,
    input  logic [19:0] acc_y,
    output logic        cell_valid,
    input  logic        cell_ready,
    output logic [19:0] cell_sum,
    output logic [4:0]  cell_idx,
    output logic        cell_hit,
    output logic        frame_done,
    output logic        sof_err
);

    localparam int CNT_W = $clog2(POINTS_PER_CELL);

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        ACCUM  = 2'd1,
        SETTLE = 2'd2,
        EMIT   = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] pt_cnt_q;
    logic [4:0]       cell_idx_q;
    logic [19:0]      cell_sum_q;
    logic             cell_hit_q;
    logic             frame_done_q;
    logic             sof_err_q;

    logic             resync;
    logic             accept;

    // A start-of-frame anywhere but point 0 of cell 0 means we lost
    // alignment: refuse the sample, restart the frame, then take it as point 0.
    assign resync   = (state_q == ACCUM) && in_valid && in_sof &&
                      ((pt_cnt_q != '0) || (cell_idx_q != '0));
    assign in_ready = (state_q == ACCUM) && !resync;
    assign accept   = in_valid & in_ready;

    assign acc_ce   = accept;
    assign acc_a    = in_intensity;
    // Decoded straight from the state register so the accumulator reset is glitch-free.
    assign acc_clr  = (state_q == CLEAR);

    assign cell_valid = (state_q == EMIT);
    assign cell_sum   = cell_sum_q;
    assign cell_idx   = cell_idx_q;
    assign cell_hit   = cell_hit_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CLEAR;
            pt_cnt_q     <= '0;
            cell_idx_q   <= '0;
            cell_sum_q   <= '0;
            cell_hit_q   <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            case (state_q)
                CLEAR: begin
                    pt_cnt_q <= '0;
                    state_q  <= ACCUM;
                end
                ACCUM: begin
                    if (resync) begin
                        sof_err_q  <= 1'b1;
                        cell_idx_q <= '0;
                        state_q    <= CLEAR;
                    end else if (accept) begin
                        pt_cnt_q <= pt_cnt_q + 1'b1;
                        if (pt_cnt_q == CNT_W'(POINTS_PER_CELL - 1)) begin
                            state_q <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    // acc_y already includes the last point accepted on the previous edge.
                    cell_sum_q <= acc_y;
                    cell_hit_q <= (acc_y >= THRESHOLD);
                    state_q    <= EMIT;
                end
                EMIT: begin
                    if (cell_ready) begin
                        state_q <= CLEAR;
                        if (cell_idx_q == 5'(CELLS_PER_ROW - 1)) begin
                            cell_idx_q   <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            cell_idx_q <= cell_idx_q + 5'd1;
                        end
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_intensity_cell_ctrl.sv
// tb/tb_intensity_cell_ctrl.sv - self-checking bench for intensity_cell_ctrl
module tb_intensity_cell_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_intensity = 8'd0;
    logic        in_sof = 1'b0;
    logic        acc_ce;
    logic        acc_clr;
    logic [7:0]  acc_a;
    logic [19:0] acc_y;
    logic        cell_valid;
    logic        cell_ready = 1'b0;
    logic [19:0] cell_sum;
    logic [4:0]  cell_idx;
    logic        cell_hit;
    logic        frame_done;
    logic        sof_err;

    int checks = 0;
    int failures = 0;

    intensity_cell_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_intensity (in_intensity),
        .in_sof       (in_sof),
        .acc_ce       (acc_ce),
        .acc_clr      (acc_clr),
        .acc_a        (acc_a),
        .acc_y        (acc_y),
        .cell_valid   (cell_valid),
        .cell_ready   (cell_ready),
        .cell_sum     (cell_sum),
        .cell_idx     (cell_idx),
        .cell_hit     (cell_hit),
        .frame_done   (frame_done),
        .sof_err      (sof_err)
    );

    always #5 clk = ~clk;

    // External 20-bit accumulator: clear on acc_clr, add operand when enabled.
    logic [19:0] acc_q;
    always @(posedge clk or posedge rst) begin
        if (rst)          acc_q <= 20'd0;
        else if (acc_clr) acc_q <= 20'd0;
        else if (acc_ce)  acc_q <= acc_q + {12'd0, acc_a};
    end
    assign acc_y = acc_q;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v, input logic sof);
        int w;
        in_valid     = 1'b1;
        in_intensity = v;
        in_sof       = sof;
        #1;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout actual=%0d expected=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic feed(input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) send(v, 1'b0);
    endtask

    task automatic wait_valid();
        int w;
        w = 0;
        while (!cell_valid && w < 300) begin
            tick();
            w++;
        end
        if (!cell_valid) begin
            failures++;
            $display("FAIL wait_valid_timeout actual=%0d expected=1", cell_valid);
        end
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        cell_ready = 1'b0;
        rst        = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int val;
        int stall;
        int exp_sum;
        int exp_hit;
        int exp_idx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int bad;
        int ref_sum;
        int n;
        int cyc;

        vecs[0] = '{255, 0,  24480, 1, 0};
        vecs[1] = '{100, 10, 9600,  0, 1};
        vecs[2] = '{125, 3,  12000, 1, 2};
        vecs[3] = '{124, 0,  11904, 0, 3};
        vecs[4] = '{0,   0,  0,     0, 4};

        // Reset values, with a valid start-of-frame sample offered during reset.
        in_valid = 1'b1;
        in_sof   = 1'b1;
        tick();
        tick();
        check("rst_acc_clr",    int'(acc_clr), 1);
        check("rst_in_ready",   int'(in_ready), 0);
        check("rst_acc_ce",     int'(acc_ce), 0);
        check("rst_cell_valid", int'(cell_valid), 0);
        check("rst_cell_sum",   int'(cell_sum), 0);
        check("rst_cell_idx",   int'(cell_idx), 0);
        check("rst_cell_hit",   int'(cell_hit), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_sof_err",    int'(sof_err), 0);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst      = 1'b0;
        #1;
        check("post_rst_clear_ready", int'(in_ready), 0);
        tick();
        check("post_rst_accum_ready", int'(in_ready), 1);
        check("post_rst_acc_clr",     int'(acc_clr), 0);

        // Table-driven cells with optional downstream stall.
        for (int i = 0; i < 5; i++) begin
            cell_ready = 1'b0;
            feed(96, 8'(vecs[i].val));
            check("lat_settle_valid", int'(cell_valid), 0);
            tick();
            check("lat_valid", int'(cell_valid), 1);
            check("cell_sum",  int'(cell_sum), vecs[i].exp_sum);
            check("cell_hit",  int'(cell_hit), vecs[i].exp_hit);
            check("cell_idx",  int'(cell_idx), vecs[i].exp_idx);
            in_valid     = 1'b1;
            in_intensity = 8'hAA;
            #1;
            bad = 0;
            for (int s = 0; s < vecs[i].stall; s++) begin
                if (cell_valid !== 1'b1 || int'(cell_sum) != vecs[i].exp_sum ||
                    int'(cell_idx) != vecs[i].exp_idx || in_ready !== 1'b0 || acc_ce !== 1'b0)
                    bad++;
                tick();
            end
            if (vecs[i].stall > 0) check("stall_stable", bad, 0);
            in_valid   = 1'b0;
            cell_ready = 1'b1;
            tick();
            cell_ready = 1'b0;
            check("accept_acc_clr",    int'(acc_clr), 1);
            check("accept_cell_valid", int'(cell_valid), 0);
            check("accept_in_ready",   int'(in_ready), 0);
            tick();
            check("clr_single_cycle",  int'(acc_clr), 0);
        end

        // Full frame of 30 cells with cell_ready tied high.
        do_reset();
        cell_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            feed(96, 8'd1);
            wait_valid();
            check("frame_idx", int'(cell_idx), c);
            check("frame_sum", int'(cell_sum), 96);
            tick();
            check("frame_done", int'(frame_done), (c == 29) ? 1 : 0);
        end
        tick();
        check("frame_done_one_cycle", int'(frame_done), 0);
        feed(96, 8'd1);
        wait_valid();
        check("frame_wrap_idx", int'(cell_idx), 0);
        tick();

        // Misplaced start-of-frame at point 40 of cell 2.
        do_reset();
        cell_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            feed(96, 8'd2);
            wait_valid();
            tick();
        end
        feed(40, 8'd3);
        in_valid     = 1'b1;
        in_sof       = 1'b1;
        in_intensity = 8'd7;
        #1;
        check("resync_in_ready", int'(in_ready), 0);
        check("resync_acc_ce",   int'(acc_ce), 0);
        tick();
        check("resync_sof_err",  int'(sof_err), 1);
        check("resync_acc_clr",  int'(acc_clr), 1);
        check("resync_idx",      int'(cell_idx), 0);
        tick();
        check("resync_sof_err_end", int'(sof_err), 0);
        check("resync_ready_again", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        feed(95, 8'd3);
        wait_valid();
        check("resync_sum", int'(cell_sum), 7 + 95 * 3);
        check("resync_cell_idx", int'(cell_idx), 0);
        tick();

        // Random gaps and intensities against a reference sum.
        cell_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            ref_sum = 0;
            n = 0;
            cyc = 0;
            bad = 0;
            while (n < 96 && cyc < 1000) begin
                in_valid     = 1'($urandom_range(0, 1));
                in_intensity = 8'($urandom_range(0, 255));
                #1;
                if (acc_ce !== (in_valid & in_ready)) bad++;
                if (in_valid && in_ready) begin
                    ref_sum += int'(in_intensity);
                    n++;
                end
                tick();
                cyc++;
            end
            in_valid = 1'b0;
            check("rand_count", n, 96);
            check("rand_acc_ce", bad, 0);
            wait_valid();
            check("rand_sum", int'(cell_sum), ref_sum);
            check("rand_hit", int'(cell_hit), (ref_sum >= 12000) ? 1 : 0);
            check("rand_idx", int'(cell_idx), 1 + c);
            tick();
        end

        // Reset in the middle of a cell.
        cell_ready = 1'b0;
        feed(50, 8'd9);
        in_valid = 1'b1;
        rst      = 1'b1;
        #1;
        check("midrst_acc_clr",    int'(acc_clr), 1);
        check("midrst_in_ready",   int'(in_ready), 0);
        check("midrst_acc_ce",     int'(acc_ce), 0);
        check("midrst_cell_valid", int'(cell_valid), 0);
        check("midrst_cell_sum",   int'(cell_sum), 0);
        check("midrst_cell_idx",   int'(cell_idx), 0);
        check("midrst_cell_hit",   int'(cell_hit), 0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        feed(96, 8'd4);
        wait_valid();
        check("midrst_next_sum", int'(cell_sum), 384);
        check("midrst_next_idx", int'(cell_idx), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intensity_cell_ctrl.md
# intensity_cell_ctrl

Sequencing stage wrapped around the 20-bit intensity accumulator in the LiDAR path. It accepts a stream of 8-bit point intensities and groups them into fixed-size cells. It drives the accumulator's clock-enable, clear and operand, then captures each completed cell sum, compares it with a threshold and hands the result downstream over a valid/ready handshake together with the cell index.

## Interface
Parameters:
- POINTS_PER_CELL, 96: points summed per cell; must satisfy POINTS_PER_CELL*255 < 2^20.
- CELLS_PER_ROW, 30: cells per frame; cell_idx wraps after CELLS_PER_ROW-1.
- THRESHOLD, 20'd12000: cell_hit is set when the captured sum >= THRESHOLD.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: intensity sample valid.
- in_ready, output, 1: block accepts the sample this cycle.
- in_intensity, input, 8: point intensity.
- in_sof, input, 1: sample is the first point of a frame.
- acc_ce, output, 1: accumulator enable; equals in_valid & in_ready.
- acc_clr, output, 1: accumulator clear; drives the accumulator's rst.
- acc_a, output, 8: accumulator operand; equals in_intensity (combinational passthrough).
- acc_y, input, 20: accumulator registered sum.
- cell_valid, output, 1: cell result valid.
- cell_ready, input, 1: downstream accepts the result.
- cell_sum, output, 20: captured cell sum.
- cell_idx, output, 5: index of the cell, 0..CELLS_PER_ROW-1.
- cell_hit, output, 1: cell_sum >= THRESHOLD.
- frame_done, output, 1: one-cycle pulse when the last cell of a frame is accepted.
- sof_err, output, 1: one-cycle pulse on a frame resync.

## Operation
- FSM states: CLEAR, ACCUM, SETTLE, EMIT. The reset state is CLEAR.
- CLEAR:
  - acc_clr=1 and in_ready=0.
  - pt_cnt<=0, then go to ACCUM.
  - Exactly one cycle per visit. acc_clr is decoded from the state register only (glitch-free).
- ACCUM:
  - in_ready=1 unless a resync applies (below).
  - On acceptance: pt_cnt++.
  - If pt_cnt==POINTS_PER_CELL-1 at acceptance, go to SETTLE.
- Resync:
  - Condition: in ACCUM, in_valid & in_sof while (pt_cnt!=0 or cell_idx!=0).
  - in_ready=0 that cycle and the sample is not accepted.
  - sof_err pulses, cell_idx<=0, go to CLEAR; the partial cell is discarded.
  - The same sample is accepted afterwards as point 0 of cell 0.
  - in_sof on point 0 of cell 0 is accepted normally.
- SETTLE:
  - in_ready=0.
  - cell_sum<=acc_y, cell_hit<=(acc_y>=THRESHOLD), then go to EMIT.
- EMIT:
  - cell_valid=1; cell_sum, cell_idx and cell_hit are held stable.
  - On cell_ready: go to CLEAR.
  - If cell_idx==CELLS_PER_ROW-1: cell_idx<=0 and frame_done pulses. Otherwise cell_idx++.
  - in_valid is ignored while in EMIT (in_ready=0).
- Arithmetic:
  - Unsigned compare on 20 bits.
  - pt_cnt width is clog2(POINTS_PER_CELL).
  - No saturation is needed, given the parameter constraint.
- Reset mid-operation:
  - Any partial cell is discarded and cell_idx returns to 0.
  - The accumulator is cleared because acc_clr=1 in the reset state.

## Timing
- Reset values: state=CLEAR, acc_clr=1, in_ready=0, acc_ce=0, cell_valid=0, cell_sum=0, cell_idx=0, cell_hit=0, frame_done=0, sof_err=0.
- After rst deasserts: first clk edge goes to ACCUM; in_ready=1 from the following cycle.
- Accumulator contract: acc_y reflects a sample at the edge on which acc_ce=1 is sampled (zero-latency adder plus register).
- Latency: last point accepted at edge E0 → SETTLE → capture at E1 → cell_valid high after E1. That is 2 cycles from last accept to valid.
- Cell period with cell_ready tied high: POINTS_PER_CELL + 3 cycles (SETTLE, EMIT, CLEAR).
- in_ready is a function of state, pt_cnt, cell_idx, in_valid and in_sof only; it never depends on cell_ready.
- frame_done and sof_err are registered, one cycle long, asserted the cycle after the causing edge.

## Test plan
- Reset, then 96 samples of 0xFF with in_valid=1 → cell_valid after 2 cycles, cell_sum=24480, cell_hit=1, cell_idx=0; acc_clr pulses once before the next cell.
- 96 samples of value 100, cell_ready held low for 10 cycles → cell_sum=9600, cell_hit=0; outputs stable and in_ready=0 throughout the stall; no samples are lost afterwards.
- 30 consecutive cells of value 1 → cell_idx runs 0..29; frame_done pulses on acceptance of cell 29; the next cell_idx is 0 and each cell_sum=96.
- in_sof asserted on point 40 of cell 2 → sample not accepted that cycle, sof_err pulses, acc_clr pulses; the sample is then counted as point 0 of cell 0; the next cell_idx=0.
- Random in_valid gaps (~50%) with random intensities → each cell_sum equals the reference sum of 96 accepted samples; acc_ce=1 exactly on accepted cycles.
- rst asserted mid-cell at point 50 → all outputs at reset values; the next cell sums only post-reset samples with cell_idx=0.
